// File: rtl/cache_types_pkg.sv
// ============================================================================
// Module      : cache_types_pkg
// Description : Shared line/burst geometry and adaptor state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_types_pkg;

  localparam int S_LINE  = 256;
  localparam int S_BURST = 64;
  localparam int S_BEATS = S_LINE / S_BURST;
  localparam int S_CNT_W = $clog2(S_BEATS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } adaptor_state_e;

  // Clears the byte-offset bits so bursts always start on a line boundary.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & ~32'(S_LINE / 8 - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/burst_shifter.sv
// ============================================================================
// Module      : burst_shifter
// Description : Line buffer with beat counter; serialises write-back lines
//               and assembles fill lines one memory beat at a time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module burst_shifter
  import cache_types_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_load,
  input  logic [S_LINE-1:0]  i_line,
  input  logic               i_rd_beat,
  input  logic               i_wr_beat,
  input  logic [S_BURST-1:0] i_burst,
  output logic [S_LINE-1:0]  o_fill,
  output logic [S_BURST-1:0] o_beat,
  output logic               o_last
);

  logic [S_LINE-1:0]  r_buf;
  logic [S_CNT_W-1:0] r_count;
  logic [S_BURST-1:0] r_beat;
  logic [S_CNT_W-1:0] w_next;

  assign w_next = r_count + S_CNT_W'(1);
  assign o_last = (r_count == S_CNT_W'(S_BEATS - 1));
  assign o_beat = r_beat;

  // Completed line as it will look once the beat on i_burst is stored.
  always_comb begin
    o_fill = r_buf;
    o_fill[int'(r_count) * S_BURST +: S_BURST] = i_burst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf   <= '0;
      r_count <= '0;
      r_beat  <= '0;
    end else begin
      if (i_clear) begin
        r_count <= '0;
      end else if (i_rd_beat || i_wr_beat) begin
        r_count <= w_next;
      end

      // The outgoing beat is pre-fetched so burst_o comes straight from a flop.
      if (i_load) begin
        r_buf  <= i_line;
        r_beat <= i_line[S_BURST-1:0];
      end else if (i_rd_beat) begin
        r_buf[int'(r_count) * S_BURST +: S_BURST] <= i_burst;
      end else if (i_wr_beat) begin
        r_beat <= r_buf[int'(w_next) * S_BURST +: S_BURST];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cacheline_adaptor.sv
// ============================================================================
// Module      : cacheline_adaptor
// Description : 256-bit cache line to 4x64-bit memory burst bridge; optional
//               stall watchdog enabled by defining CLA_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cacheline_adaptor
  import cache_types_pkg::*;
`ifdef CLA_WATCHDOG_EN
#(
  parameter int S_TIMEOUT = 64
)
`endif
(
  input  logic               clk,
  input  logic               rst,
  input  logic [S_LINE-1:0]  line_i,
  output logic [S_LINE-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [S_BURST-1:0] burst_i,
  output logic [S_BURST-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
`ifdef CLA_WATCHDOG_EN
  ,
  output logic               err_o
`endif
);

  adaptor_state_e    r_state;
  adaptor_state_e    w_state_next;
  logic              w_clear;
  logic              w_load;
  logic              w_rd_beat;
  logic              w_wr_beat;
  logic              w_fill_done;
  logic              w_abort;
  logic              w_last;
  logic [S_LINE-1:0] w_fill;

`ifdef CLA_WATCHDOG_EN
  localparam int c_wd_w = $clog2(S_TIMEOUT);
  logic [c_wd_w-1:0] r_wd_cnt;
`endif

  burst_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_load    (w_load),
    .i_line    (line_i),
    .i_rd_beat (w_rd_beat),
    .i_wr_beat (w_wr_beat),
    .i_burst   (burst_i),
    .o_fill    (w_fill),
    .o_beat    (burst_o),
    .o_last    (w_last)
  );

  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_load       = 1'b0;
    w_rd_beat    = 1'b0;
    w_wr_beat    = 1'b0;
    w_fill_done  = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (write_i) begin
          w_state_next = ST_WRITE;
          w_clear      = 1'b1;
          w_load       = 1'b1;
        end else if (read_i) begin
          w_state_next = ST_READ;
          w_clear      = 1'b1;
        end
      end
      ST_READ: begin
        if (resp_i) begin
          w_rd_beat = 1'b1;
          if (w_last) begin
            w_state_next = ST_DONE;
            w_fill_done  = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (resp_i) begin
          w_wr_beat = 1'b1;
          if (w_last) begin
            w_state_next = ST_DONE;
          end
        end
      end
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
`ifdef CLA_WATCHDOG_EN
    if ((r_state == ST_READ || r_state == ST_WRITE) && !resp_i &&
        r_wd_cnt == c_wd_w'(S_TIMEOUT - 1)) begin
      w_state_next = ST_IDLE;
      w_abort      = 1'b1;
    end
`endif
  end

  // Outputs are decoded from the next state so every port is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
      address_o <= '0;
      line_o    <= '0;
    end else begin
      r_state <= w_state_next;
      read_o  <= (w_state_next == ST_READ);
      write_o <= (w_state_next == ST_WRITE);
      resp_o  <= (w_state_next == ST_DONE) || w_abort;
      if (w_clear) begin
        address_o <= line_align(address_i);
      end
      if (w_fill_done) begin
        line_o <= w_fill;
      end
    end
  end

`ifdef CLA_WATCHDOG_EN
  // Counts cycles since the last accepted beat while a burst is open.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt <= '0;
      err_o    <= 1'b0;
    end else begin
      err_o <= w_abort;
      if ((r_state != ST_READ && r_state != ST_WRITE) || resp_i || w_abort) begin
        r_wd_cnt <= '0;
      end else begin
        r_wd_cnt <= r_wd_cnt + c_wd_w'(1);
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cacheline_adaptor.sv
// ============================================================================
// Module      : tb_cacheline_adaptor
// Description : Self-checking bench for cacheline_adaptor; transaction model
//               plus directed read/write/reset scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] line_i = '0;
  logic [255:0] line_o;
  logic [31:0]  address_i = '0;
  logic         read_i = 1'b0;
  logic         write_i = 1'b0;
  logic         resp_o;
  logic [63:0]  burst_i = '0;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i = 1'b0;
`ifdef CLA_WATCHDOG_EN
  logic         err_o;
  localparam int WD = 8;
`endif

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

`ifdef CLA_WATCHDOG_EN
  cacheline_adaptor #(.S_TIMEOUT(WD)) dut (
`else
  cacheline_adaptor dut (
`endif
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
`ifdef CLA_WATCHDOG_EN
    ,
    .err_o     (err_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: one open request, counted beats, assembled line.
  bit           m_busy = 0, m_wr = 0, m_done = 0;
  int           m_beats = 0, m_idle = 0;
  logic [63:0]  m_rd [4];
  logic [255:0] m_wline = '0;
  logic [31:0]  e_addr = '0;
  logic [255:0] e_line = '0;
  logic [63:0]  e_burst = '0;
  bit           e_resp = 0, e_err = 0;

  always @(posedge clk) begin
    started = 1'b1;
    e_resp  = 1'b0;
    e_err   = 1'b0;
    if (rst) begin
      m_busy = 0; m_done = 0;
      e_addr = '0; e_line = '0; e_burst = '0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_busy) begin
      if (write_i || read_i) begin
        m_busy  = 1;
        m_wr    = write_i;
        m_beats = 0;
        m_idle  = 0;
        e_addr  = address_i & ~32'h1F;
        if (write_i) begin
          m_wline = line_i;
          e_burst = line_i[63:0];
        end
      end
    end else if (resp_i) begin
      m_idle = 0;
      if (!m_wr) m_rd[m_beats] = burst_i;
      m_beats++;
      if (m_wr) e_burst = m_wline[64*(m_beats%4) +: 64];
      if (m_beats == 4) begin
        m_busy = 0;
        m_done = 1;
        e_resp = 1;
        if (!m_wr) e_line = {m_rd[3], m_rd[2], m_rd[1], m_rd[0]};
      end
    end
`ifdef CLA_WATCHDOG_EN
    else begin
      m_idle++;
      if (m_idle == WD) begin
        m_busy = 0;
        e_resp = 1;
        e_err  = 1;
      end
    end
`endif
  end

  always @(negedge clk) begin
    if (started) begin
      chk("resp_o",    resp_o,    e_resp);
      chk("read_o",    read_o,    m_busy && !m_wr);
      chk("write_o",   write_o,   m_busy && m_wr);
      chk("address_o", address_o, e_addr);
      chk("line_o",    line_o,    e_line);
      chk("burst_o",   burst_o,   e_burst);
`ifdef CLA_WATCHDOG_EN
      chk("err_o",     err_o,     e_err);
`endif
    end
  end

  // Drives one request; bit n of mask raises resp_i in cycle n (request cycle = 0).
  task automatic run_txn(input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [255:0] wline, input logic [15:0] mask,
                         input logic [63:0] rd_base, output int resp_cyc,
                         output logic [255:0] seen);
    int k;
    k = 0;
    resp_cyc = -1;
    seen = '0;
    @(negedge clk);
    write_i = wr; read_i = rd; address_i = addr; line_i = wline;
    for (int n = 0; n < 40; n++) begin
      if (n > 0) @(negedge clk);
      if (resp_o) begin
        resp_cyc = n;
        break;
      end
      resp_i  = (n < 16) ? mask[n] : 1'b0;
      burst_i = rd_base + 64'(k);
      if (resp_i && write_o && k < 4) seen[64*k +: 64] = burst_o;
      if (resp_i) k++;
    end
    read_i = 0; write_i = 0; resp_i = 0;
  endtask

  logic [255:0] fill_a, wr_line, sim_line, seen;
  int           rc, nresp;

  initial begin
    fill_a  = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    wr_line = {64'hDDDD_0000_0000_0003, 64'hDDDD_0000_0000_0002,
               64'hDDDD_0000_0000_0001, 64'hDDDD_0000_0000_0000};
    sim_line = {64'h5A5A_0003, 64'h5A5A_0002, 64'h5A5A_0001, 64'h5A5A_0000};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_resp",  resp_o,    0);
    chk("rst_read",  read_o,    0);
    chk("rst_write", write_o,   0);
    chk("rst_addr",  address_o, 0);
    chk("rst_line",  line_o,    0);
    chk("rst_burst", burst_o,   0);

    // resp_i chatter while idle must not move anything.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      resp_i  = i[0];
      burst_i = 64'hFFFF_0000 + 64'(i);
    end
    @(negedge clk);
    resp_i = 0;
    @(negedge clk);
    chk("idle_state", {resp_o, read_o, write_o}, 0);
    chk("idle_line",  line_o, 0);
    chk("idle_addr",  address_o, 0);

    run_txn(0, 1, 32'h0000_125C, '0, 16'h003C, 64'hA0, rc, seen);
    chk("rd_resp_cycle", rc, 6);
    chk("rd_line",       line_o, fill_a);
    chk("rd_addr",       address_o, 32'h0000_1240);

    run_txn(1, 0, 32'h0000_3FE4, wr_line, 16'h0134, 64'h0, rc, seen);
    chk("wr_resp_cycle", rc, 9);
    chk("wr_beats",      seen, wr_line);
    chk("wr_line_keep",  line_o, fill_a);
    chk("wr_addr",       address_o, 32'h0000_3FE0);

    run_txn(1, 1, 32'h0000_0044, sim_line, 16'h003C, 64'hBB, rc, seen);
    chk("sim_resp_cycle", rc, 6);
    chk("sim_beats",      seen, sim_line);
    chk("sim_line_keep",  line_o, fill_a);

    // Reset in cycle 3 of a read.
    @(negedge clk);
    read_i = 1; address_i = 32'h0000_2000;
    @(negedge clk);
    @(negedge clk);
    resp_i = 1; burst_i = 64'hEE;
    @(negedge clk);
    resp_i = 0; rst = 1;
    @(negedge clk);
    chk("mid_rst_read", read_o, 0);
    rst = 0; read_i = 0;
    nresp = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_o) nresp++;
    end
    chk("mid_rst_no_resp", nresp, 0);
    chk("mid_rst_line",    line_o, 0);

    run_txn(0, 1, 32'h0000_8008, '0, 16'h00CC, 64'h55, rc, seen);
    chk("rd2_resp_cycle", rc, 8);
    chk("rd2_line", line_o, {64'h58, 64'h57, 64'h56, 64'h55});

`ifdef CLA_WATCHDOG_EN
    run_txn(0, 1, 32'h0000_0100, '0, 16'h0000, 64'h0, rc, seen);
    chk("wd_resp_cycle", rc, 9);
    chk("wd_err",        err_o, 1);
    @(negedge clk);
    chk("wd_read_low",   read_o, 0);
    chk("wd_err_pulse",  err_o, 0);
    chk("wd_line_keep",  line_o, {64'h58, 64'h57, 64'h56, 64'h55});
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
